// File: rtl/vae_fwd_pkg.sv
// Shared definitions for the VAE forward-path layers: activation codes,
// default Q-format, FSM encoding and the accumulator shift/saturate helper.
package vae_fwd_pkg;

  localparam int ACT_NONE = 0;
  localparam int ACT_RELU = 1;
  localparam int ACT_HSIG = 2;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC_W = 8;

  // Working width for sat_shift; any accumulator up to this width is accepted.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_FIN,
    ST_DONE
  } dense_state_t;

  // Arithmetic shift right by frac_w (floor), then clamp to a signed data_w range.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input int                      data_w,
    input int                      frac_w
  );
    logic signed [SAT_W-1:0] t;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    t  = acc >>> frac_w;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (t > hi) begin
      return hi;
    end else if (t < lo) begin
      return lo;
    end
    return t;
  endfunction

endpackage

// File: rtl/vae_q_act.sv
// Combinational requantiser: accumulator -> saturated DATA_W word -> activation.
module vae_q_act
  import vae_fwd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = 2 * DEF_DATA_W + 4,
  parameter int ACT    = ACT_NONE
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] y
);

  localparam logic signed [DATA_W+1:0] HALF = (DATA_W+2)'(2 ** (FRAC_W - 1));
  localparam logic signed [DATA_W+1:0] ONE  = (DATA_W+2)'(2 ** FRAC_W);

  logic signed [DATA_W-1:0] sat;

  // Two guard bits keep the +0.5 offset from wrapping before the clamp.
  function automatic logic signed [DATA_W-1:0] hsig(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W+1:0] h;
    h = (DATA_W+2)'(v >>> 2) + HALF;
    if (h < 0) begin
      return '0;
    end else if (h > ONE) begin
      return DATA_W'(ONE);
    end
    return DATA_W'(h);
  endfunction

  assign sat = DATA_W'(sat_shift(SAT_W'(acc), DATA_W, FRAC_W));

  always_comb begin
    y = sat;
    case (ACT)
      ACT_RELU: y = sat[DATA_W-1] ? '0 : sat;
      ACT_HSIG: y = hsig(sat);
      default:  y = sat;
    endcase
  end

endmodule

// File: rtl/vae_dense_seq.sv
// Time-multiplexed fixed-point dense layer: one MAC per cycle, one FIN cycle
// per neuron, valid/ready on both sides so layers can be chained.
module vae_dense_seq
  import vae_fwd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int N_IN   = 9,
  parameter int N_OUT  = 4,
  parameter int ACT    = ACT_NONE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_IN*DATA_W-1:0]          x_flat,
  input  logic [N_IN*N_OUT*DATA_W-1:0]    w_flat,
  input  logic [N_OUT*DATA_W-1:0]         b_flat,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N_OUT*DATA_W-1:0]         y_flat,
  output logic                            busy
);

  localparam int ACC_W = 2 * DATA_W + $clog2(N_IN + 1);
  localparam int IW    = $clog2(N_IN + 1);
  localparam int JW    = $clog2(N_OUT + 1);

  dense_state_t state, state_nx;

  logic [IW-1:0]               i;
  logic [JW-1:0]               j;
  logic signed [ACC_W-1:0]     acc;
  logic [N_IN*DATA_W-1:0]      x_reg;
  logic [N_OUT*DATA_W-1:0]     y_reg;

  logic signed [DATA_W-1:0]    x_sel;
  logic signed [DATA_W-1:0]    w_sel;
  logic signed [DATA_W-1:0]    b_sel;
  logic signed [2*DATA_W-1:0]  prod;
  logic signed [ACC_W-1:0]     bias_ext;
  logic signed [DATA_W-1:0]    y_act;
  logic                        last_i;
  logic                        last_j;

  assign x_sel    = x_reg[int'(i)*DATA_W +: DATA_W];
  assign w_sel    = w_flat[(int'(j)*N_IN + int'(i))*DATA_W +: DATA_W];
  assign b_sel    = b_flat[int'(j)*DATA_W +: DATA_W];
  assign prod     = (2*DATA_W)'(x_sel) * (2*DATA_W)'(w_sel);
  assign bias_ext = ACC_W'(b_sel) <<< FRAC_W;
  assign last_i   = (i == IW'(N_IN - 1));
  assign last_j   = (j == JW'(N_OUT - 1));

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign y_flat    = y_reg;

  vae_q_act #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W),
    .ACT    (ACT)
  ) u_q_act (
    .acc (acc),
    .y   (y_act)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nx = ST_MAC;
      ST_MAC:  if (last_i)    state_nx = ST_FIN;
      ST_FIN:  state_nx = last_j ? ST_DONE : ST_MAC;
      ST_DONE: if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      i     <= '0;
      j     <= '0;
      acc   <= '0;
      x_reg <= '0;
      y_reg <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_reg <= x_flat;
            i     <= '0;
            j     <= '0;
          end
        end
        // First product of a neuron seeds the accumulator with the aligned bias.
        ST_MAC: begin
          acc <= ((i == '0) ? bias_ext : acc) + ACC_W'(prod);
          i   <= last_i ? '0 : i + IW'(1);
        end
        ST_FIN: begin
          y_reg[int'(j)*DATA_W +: DATA_W] <= y_act;
          i <= '0;
          if (!last_j) j <= j + JW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vae_dense_seq.sv
// Randomised self-checking bench: three layer instances (identity, ReLU,
// hard-sigmoid) share stimulus and are compared with an arithmetic reference.
module tb_vae_dense_seq;

  localparam int DW  = 16;
  localparam int FW  = 8;
  localparam int NI  = 9;
  localparam int NO  = 4;
  localparam int LAT = NO * (NI + 1);

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic out_ready;
  logic [NI*DW-1:0]    x_flat;
  logic [NI*NO*DW-1:0] w_flat;
  logic [NO*DW-1:0]    b_flat;

  logic             in_ready_a  [3];
  logic             out_valid_a [3];
  logic             busy_a      [3];
  logic [NO*DW-1:0] y_flat_a    [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vae_dense_seq #(
      .DATA_W (DW),
      .FRAC_W (FW),
      .N_IN   (NI),
      .N_OUT  (NO),
      .ACT    (g)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_a[g]),
      .x_flat    (x_flat),
      .w_flat    (w_flat),
      .b_flat    (b_flat),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready),
      .y_flat    (y_flat_a[g]),
      .busy      (busy_a[g])
    );
  end

  int n_chk = 0;
  int n_err = 0;

  logic signed [DW-1:0] xv [NI];
  logic signed [DW-1:0] wv [NO][NI];
  logic signed [DW-1:0] bv [NO];
  logic [NO*DW-1:0]     snap [3];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NI; i++) x_flat[i*DW +: DW] = xv[i];
    for (int j = 0; j < NO; j++) begin
      b_flat[j*DW +: DW] = bv[j];
      for (int i = 0; i < NI; i++) w_flat[(j*NI+i)*DW +: DW] = wv[j][i];
    end
  endtask

  function automatic longint y_of(int g, int j);
    return longint'($signed(y_flat_a[g][j*DW +: DW]));
  endfunction

  // y_j = act(sat(floor((b_j*2^FW + sum x_i*w_ji) / 2^FW)))
  function automatic longint ref_y(int j, int act);
    longint acc, t;
    longint hi, lo;
    acc = longint'(bv[j]) * (longint'(1) << FW);
    for (int i = 0; i < NI; i++) acc += longint'(xv[i]) * longint'(wv[j][i]);
    t  = acc >>> FW;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -(longint'(1) << (DW - 1));
    if (t > hi) t = hi;
    if (t < lo) t = lo;
    if (act == 1) begin
      if (t < 0) t = 0;
    end else if (act == 2) begin
      t = (t >>> 2) + (longint'(1) << (FW - 1));
      if (t < 0) t = 0;
      if (t > (longint'(1) << FW)) t = longint'(1) << FW;
    end
    return t;
  endfunction

  function automatic logic signed [DW-1:0] rnd(int mode);
    case (mode)
      0:       return DW'($urandom);
      1:       return DW'(int'($urandom_range(0, 2047)) - 1024);
      default: return ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'(int'($urandom_range(0, 511)) - 256);
    endcase
  endfunction

  task automatic rand_vec(int mode);
    for (int i = 0; i < NI; i++) xv[i] = rnd(mode);
    for (int j = 0; j < NO; j++) begin
      bv[j] = rnd(mode);
      for (int i = 0; i < NI; i++) wv[j][i] = rnd(mode);
    end
  endtask

  task automatic run_vec(input string tag, input bit release_out);
    int lat;
    pack();
    @(negedge clk);
    chk({tag, "_in_ready"}, longint'(in_ready_a[0]), 1);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({tag, "_busy"}, longint'(busy_a[0]), 1);
    lat = -1;
    for (int c = 1; c <= LAT + 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid_a[0]) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_latency"}, longint'(lat), longint'(LAT));
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_ov_act%0d", tag, g), longint'(out_valid_a[g]), 1);
      for (int j = 0; j < NO; j++)
        chk($sformatf("%s_y%0d_act%0d", tag, j, g), y_of(g, j), ref_y(j, g));
    end
    if (release_out) begin
      @(posedge clk);
      #1;
      chk({tag, "_idle_in_ready"}, longint'(in_ready_a[0]), 1);
      chk({tag, "_idle_out_valid"}, longint'(out_valid_a[0]), 0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    foreach (xv[i]) xv[i] = '0;
    foreach (bv[j]) bv[j] = '0;
    foreach (wv[j, i]) wv[j][i] = '0;
    pack();
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_in_ready%0d", g), longint'(in_ready_a[g]), 1);
      chk($sformatf("rst_out_valid%0d", g), longint'(out_valid_a[g]), 0);
      chk($sformatf("rst_busy%0d", g), longint'(busy_a[g]), 0);
      chk($sformatf("rst_y%0d", g), longint'(y_flat_a[g]), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // 1.0 * 1.0 summed over nine inputs
    foreach (xv[i]) xv[i] = 16'h0100;
    foreach (wv[j, i]) wv[j][i] = 16'h0100;
    run_vec("ones", 1'b1);
    for (int j = 0; j < NO; j++) chk($sformatf("ones_const_y%0d", j), y_of(0, j), 64'sh0900);

    foreach (xv[i]) xv[i] = 16'h7FFF;
    foreach (wv[j, i]) wv[j][i] = 16'h7FFF;
    foreach (bv[j]) bv[j] = 16'h7FFF;
    run_vec("sat_pos", 1'b1);
    chk("sat_pos_const", y_of(0, 0), 32767);
    foreach (wv[j, i]) wv[j][i] = -16'sh7FFF;
    run_vec("sat_neg", 1'b1);
    chk("sat_neg_const", y_of(0, 3), -32768);

    foreach (wv[j, i]) wv[j][i] = '0;
    foreach (xv[i]) xv[i] = DW'($urandom);
    bv[0] = 16'hFF00; bv[1] = 16'h0180; bv[2] = 16'h0400; bv[3] = 16'hFC00;
    run_vec("bias_act", 1'b1);
    chk("relu_neg", y_of(1, 0), 0);
    chk("relu_pos", y_of(1, 1), 16'h0180);
    chk("hsig_hi", y_of(2, 2), 16'h0100);
    chk("hsig_lo", y_of(2, 3), 0);
    foreach (bv[j]) bv[j] = '0;
    run_vec("hsig_zero", 1'b1);
    chk("hsig_mid", y_of(2, 0), 16'h0080);

    // Back-pressure: hold DONE for seven cycles with a stray in_valid pulse.
    rand_vec(2);
    out_ready = 1'b0;
    run_vec("bp", 1'b0);
    for (int g = 0; g < 3; g++) snap[g] = y_flat_a[g];
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      in_valid = (k == 3);
      if (k == 3) rand_vec(0);
      pack();
      @(posedge clk);
      #1;
      chk($sformatf("bp_ov_%0d", k), longint'(out_valid_a[0]), 1);
      chk($sformatf("bp_in_ready_%0d", k), longint'(in_ready_a[0]), 0);
      for (int g = 0; g < 3; g++)
        chk($sformatf("bp_hold_%0d_act%0d", k, g), longint'(y_flat_a[g]), longint'(snap[g]));
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", longint'(in_ready_a[0]), 1);
    chk("bp_release_out_valid", longint'(out_valid_a[0]), 0);
    @(posedge clk);
    #1;
    chk("bp_release_busy", longint'(busy_a[0]), 0);
    chk("bp_release_y", longint'(y_flat_a[0]), longint'(snap[0]));

    // Asynchronous reset in the middle of neuron 2, input 5.
    rand_vec(1);
    pack();
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (25) @(posedge clk);
    #2;
    chk("mid_busy", longint'(busy_a[0]), 1);
    rst = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("mid_rst_ov%0d", g), longint'(out_valid_a[g]), 0);
      chk($sformatf("mid_rst_y%0d", g), longint'(y_flat_a[g]), 0);
      chk($sformatf("mid_rst_in_ready%0d", g), longint'(in_ready_a[g]), 1);
      chk($sformatf("mid_rst_busy%0d", g), longint'(busy_a[g]), 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rand_vec(1);
    run_vec("after_rst", 1'b1);

    for (int n = 0; n < 12; n++) begin
      rand_vec(n % 3);
      run_vec($sformatf("rnd%0d", n), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end, got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/vae_dense_seq.md
# vae_dense_seq

Parametrised, time-multiplexed fixed-point dense layer for the VAE forward path. It computes y_j = act(b_j + Σ_i x_i·w_{j,i}) for N_OUT neurons over N_IN inputs, using one multiply-accumulate unit. It supersedes the fully-unrolled, hard-wired 9-input layers of the forward top level. Layer shape, Q-format and activation mode are parameters, and a valid/ready handshake lets layers be chained.

## Interface
- DATA_W, 16: word width; signed two's complement
- FRAC_W, 8: fraction bits (Q8.8 at defaults)
- N_IN, 9: inputs per neuron, ≥1
- N_OUT, 4: neurons, ≥1
- ACT, 0: activation select; 0 = identity, 1 = ReLU, 2 = hard-sigmoid
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  x_flat is valid
- in_ready  out  1  block can accept a vector
- x_flat  in  N_IN·DATA_W  input vector; x_i = x_flat[i·DATA_W +: DATA_W]
- w_flat  in  N_IN·N_OUT·DATA_W  weights; w_{j,i} = w_flat[(j·N_IN+i)·DATA_W +: DATA_W]
- b_flat  in  N_OUT·DATA_W  biases; b_j = b_flat[j·DATA_W +: DATA_W]
- out_valid  out  1  y_flat holds a complete result
- out_ready  in  1  downstream accepts the result
- y_flat  out  N_OUT·DATA_W  result vector; same packing as b_flat
- busy  out  1  high in every state other than IDLE

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid: register x_flat, clear i and j, go to MAC.
  - MAC: one product per cycle.
  - FIN: finalise neuron j.
  - DONE: hold the result until it is accepted.
- Weights and biases are not captured. They must stay stable from acceptance until out_valid.
- MAC, entry with i=0:
  - acc = sign-extended b_j << FRAC_W, plus x_0·w_{j,0}.
  - Each later cycle adds x_i·w_{j,i}.
  - After i = N_IN−1, go to FIN.
- Accumulator width ACC_W = 2·DATA_W + clog2(N_IN+1). Signed; never wraps.
- FIN:
  - t = acc >>> FRAC_W (arithmetic shift, truncation toward −∞).
  - Saturate t to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Apply the activation to the saturated value and write it to y_j.
  - If j = N_OUT−1, go to DONE. Otherwise j++, i=0, go to MAC.
- Activations:
  - ReLU: negative → 0.
  - Hard-sigmoid: (v >>> 2) + 2^(FRAC_W−1), clamped to [0, 2^FRAC_W], i.e. 0.0 to 1.0.
- DONE:
  - out_valid=1, y_flat stable.
  - On out_ready, go to IDLE.
  - in_ready stays 0 until the state is IDLE; there is no accept-in-same-cycle overlap.
- Unsupported ACT values behave as identity.
- Reset mid-operation aborts the computation with no partial output.
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, y_flat 0, acc 0, i 0, j 0.

## Timing
- Handshakes complete on a rising edge where valid and ready are both high.
- Latency: the accept edge is cycle 0. out_valid rises N_OUT·(N_IN+1) cycles later; 40 at defaults.
- Throughput: one vector per N_OUT·(N_IN+1)+2 cycles when out_ready is held high.
- y_j updates only in FIN. y_flat is fully stable while out_valid=1.
- Asynchronous rst forces all outputs to reset values immediately. Operation resumes on the first edge after deassertion.
- Back-pressure:
  - out_ready low keeps out_valid and y_flat unchanged indefinitely.
  - in_valid is ignored while in_ready=0.

## Structure
- Package vae_fwd_pkg holds:
  - ACT_NONE/ACT_RELU/ACT_HSIG constants
  - the Q-format defaults
  - a function sat_shift(acc) returning the saturated DATA_W value
- Sub-module vae_q_act: combinational shift + saturate + activation. It is instantiated once in the FIN path, and the future layer variants reuse it.
- The datapath has one signed DATA_W×DATA_W multiplier and x-select / w-select muxes indexed by i and j.

## Test plan
- Defaults, ACT=0, all x=0x0100, all w=0x0100, b=0 → every y_j=0x0900; out_valid rises exactly 40 cycles after acceptance.
- x=0x7FFF, w=0x7FFF, b=0x7FFF → y=0x7FFF. Negating w → y=0x8000. Checks saturation with no wrap.
- ACT=1, w=0, b=0xFF00 → y=0x0000. With b=0x0180 → y=0x0180.
- ACT=2, w=0, b=0 → y=0x0080. b=0x0400 → 0x0100. b=0xFC00 → 0x0000.
- out_ready low for 7 cycles in DONE → y_flat, out_valid held; in_ready=0; an in_valid pulse is ignored. Then out_ready=1 → IDLE next edge, in_ready=1.
- rst asserted mid-MAC (j=2, i=5) → out_valid=0, y_flat=0, in_ready=1 immediately. A new vector then completes with the correct result and full latency.
